// File: rtl/hexin_decode_if.sv
// Segment-bus interface for hexin_decode: the source drives samples, the decoder returns digits.
// HEXIN_DP_EN adds the decimal-point input/output pair.
interface hexin_decode_if;
  logic       sample_en;
  logic [6:0] seg_in;
  logic [3:0] data;
  logic       hex_en;
  logic       err;
  logic       locked;
  logic       valid;
`ifdef HEXIN_DP_EN
  logic       dp_in;
  logic       dp;

  modport master (output sample_en, seg_in, dp_in,
                  input  data, hex_en, err, locked, valid, dp);
  modport slave  (input  sample_en, seg_in, dp_in,
                  output data, hex_en, err, locked, valid, dp);
`else
  modport master (output sample_en, seg_in,
                  input  data, hex_en, err, locked, valid);
  modport slave  (input  sample_en, seg_in,
                  output data, hex_en, err, locked, valid);
`endif
endinterface

// File: rtl/hexin_decode.sv
// Active-low 7-segment receiver: debounces the sampled bus and recovers the hex digit.
// Optional macro HEXIN_DP_EN folds the decimal point into the stability check and reports it.
module hexin_decode #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input logic           clk,
  input logic           clrn,
  hexin_decode_if.slave bus
);

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_e;

`ifdef HEXIN_DP_EN
  localparam int SW = 8;
`else
  localparam int SW = 7;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [6:0]       SEG_BLNK = 7'h7F;

  logic [SW-1:0] sample_w;
`ifdef HEXIN_DP_EN
  assign sample_w = {bus.dp_in, bus.seg_in};
`else
  assign sample_w = bus.seg_in;
`endif

  state_e        state_q, state_d;
  logic [SW-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]    data_q, data_d;
  logic          hex_en_q, hex_en_d;
  logic          err_q, err_d;
  logic          valid_q, valid_d;
`ifdef HEXIN_DP_EN
  logic          dp_q, dp_d;
`endif

  // Decode table: {legal, digit}. Patterns are active-low, bit0=a .. bit6=g.
  logic       dec_legal;
  logic [3:0] dec_digit;
  always_comb begin
    dec_legal = 1'b1;
    dec_digit = 4'h0;
    unique case (bus.seg_in)
      7'b1000000: dec_digit = 4'h0;
      7'b1111001: dec_digit = 4'h1;
      7'b0100100: dec_digit = 4'h2;
      7'b0110000: dec_digit = 4'h3;
      7'b0011001: dec_digit = 4'h4;
      7'b0010010: dec_digit = 4'h5;
      7'b0000010: dec_digit = 4'h6;
      7'b1111000: dec_digit = 4'h7;
      7'b0000000: dec_digit = 4'h8;
      7'b0010000: dec_digit = 4'h9;
      7'b0001000: dec_digit = 4'hA;
      7'b0000011: dec_digit = 4'hB;
      7'b1000110: dec_digit = 4'hC;
      7'b0100001: dec_digit = 4'hD;
      7'b0000110: dec_digit = 4'hE;
      7'b0001110: dec_digit = 4'hF;
      default:    dec_legal = 1'b0;
    endcase
  end

  // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    hex_en_d = hex_en_q;
    err_d    = err_q;
    valid_d  = 1'b0;
`ifdef HEXIN_DP_EN
    dp_d     = dp_q;
`endif
    if (bus.sample_en) begin
      if (sample_w != prev_q) begin
        prev_d  = sample_w;
        cnt_d   = '0;
        state_d = ST_UNLOCKED;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end

      // cnt_d==CNT_MAX means this edge takes the STABLE_CYCLES-th identical sample.
      if (state_d == ST_UNLOCKED && cnt_d == CNT_MAX) begin
        state_d = ST_LOCKED;
        valid_d = 1'b1;
        if (dec_legal) begin
          data_d   = dec_digit;
          hex_en_d = 1'b1;
          err_d    = 1'b0;
        end else begin
          hex_en_d = 1'b0;
          err_d    = (bus.seg_in != SEG_BLNK);
        end
`ifdef HEXIN_DP_EN
        dp_d = ~bus.dp_in;
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= ST_UNLOCKED;
      prev_q   <= '1;
      cnt_q    <= '0;
      data_q   <= 4'h0;
      hex_en_q <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      hex_en_q <= hex_en_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

`ifdef HEXIN_DP_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) dp_q <= 1'b0;
    else       dp_q <= dp_d;
  end
  assign bus.dp = dp_q;
`endif

  assign bus.data   = data_q;
  assign bus.hex_en = hex_en_q;
  assign bus.err    = err_q;
  assign bus.locked = (state_q == ST_LOCKED);
  assign bus.valid  = valid_q;

endmodule
